// File: rtl/addr4u_pkg.sv
// Shared definitions for the addr4u sequencing stage.
//   OP_W    operand width of the external adder
//   SUM_W   result width (carry out included)
//   state_t controller states
package addr4u_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SUM_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC1 = 3'd1,
    EXEC2 = 3'd2,
    CMP   = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/addr4u_settle_cnt.sv
// Settle timer for the external adder.
// Loaded with SETTLE_CYC-1 when operands are (re)applied; done is high in the
// cycle whose closing edge is the last one of the hold window, i.e. the edge
// on which add_o may be sampled.
//   clk   clock
//   rst   asynchronous active-high reset
//   load  restart the hold window
//   done  sample strobe (count exhausted)
module addr4u_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYC - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/addr4u_rex_ctrl.sv
// Redundant-execution controller around an external 4-bit combinational adder.
// Each operand pair is added twice (second time swapped); differing results
// trigger re-execution up to MAX_RETRY times, and every mismatch is counted.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake, in_a/in_b operands
//   add_a/add_b/add_o    registered operands to / result from the adder
//   out_valid/out_ready  result handshake, out_sum checked sum
//   out_err              retries exhausted, out_sum unverified
//   err_cnt              saturating mismatch count since reset
module addr4u_rex_ctrl
  import addr4u_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic [OP_W-1:0]  add_a,
  output logic [OP_W-1:0]  add_b,
  input  logic [SUM_W-1:0] add_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_a, op_b;
  logic [SUM_W-1:0] r1, r2;
  logic [RW-1:0]    retry;
  logic             settle_load, settle_done;
  logic             match, can_retry;

  assign match = (r1 == r2);
  // retry never exceeds MAX_RETRY, so inequality is the "below limit" test
  assign can_retry = (MAX_RETRY != 0) && (retry != RW'(MAX_RETRY));
  // restart the hold window whenever new operands reach the adder
  assign settle_load = (state_d != state_q) &&
                       ((state_d == EXEC1) || (state_d == EXEC2));

  addr4u_settle_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle (
    .clk (clk),
    .rst (rst),
    .load(settle_load),
    .done(settle_done)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)    state_d = EXEC1;
      EXEC1:   if (settle_done) state_d = EXEC2;
      EXEC2:   if (settle_done) state_d = CMP;
      CMP:     state_d = (match || !can_retry) ? OUT : EXEC1;
      OUT:     if (out_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == OUT);
  end

  // datapath: operand latch, adder drive, result capture, compare bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      add_a   <= '0;
      add_b   <= '0;
      r1      <= '0;
      r2      <= '0;
      retry   <= '0;
      out_sum <= '0;
      out_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            add_a <= in_a;
            add_b <= in_b;
            retry <= '0;
          end
        end
        EXEC1: begin
          if (settle_done) begin
            r1    <= add_o;
            add_a <= op_b;
            add_b <= op_a;
          end
        end
        EXEC2: begin
          if (settle_done) r2 <= add_o;
        end
        CMP: begin
          if (match) begin
            out_sum <= r1;
            out_err <= 1'b0;
          end else begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (can_retry) begin
              retry <= retry + 1'b1;
              add_a <= op_a;
              add_b <= op_b;
            end else begin
              out_sum <= r2;
              out_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr4u_rex_ctrl.sv
module tb_addr4u_rex_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- u1: default parameters, configurable fault model
  logic       v1 = 0, ordy1 = 0, rdy1, ov1, err1;
  logic [3:0] a1 = 0, b1 = 0, aa1, ab1;
  logic [4:0] o1, sum1;
  logic [7:0] cnt1;
  logic       lt_fault = 0, flip_lsb = 0;

  // lt_fault: spurious LSB carry when a<b (2+5 reads 8, 5+2 reads 7)
  always_comb begin
    o1 = {1'b0, aa1} + {1'b0, ab1};
    if (lt_fault && (aa1 < ab1)) o1 = o1 + 5'd1;
    if (flip_lsb) o1 = o1 ^ 5'd1;
  end

  addr4u_rex_ctrl u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_b(b1),
    .add_a(aa1), .add_b(ab1), .add_o(o1), .out_valid(ov1), .out_ready(ordy1),
    .out_sum(sum1), .out_err(err1), .err_cnt(cnt1)
  );

  // ---------------- u2: slow netlist, result appears two cycles late
  logic       v2 = 0, rdy2, ov2, err2;
  logic [3:0] a2 = 0, b2 = 0, aa2, ab2;
  logic [4:0] o2, sum2, d1, d2;
  logic [7:0] cnt2;

  always_ff @(posedge clk) begin
    d1 <= {1'b0, aa2} + {1'b0, ab2};
    d2 <= d1;
  end
  assign o2 = d2;

  addr4u_rex_ctrl #(.SETTLE_CYC(3), .MAX_RETRY(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_a(a2), .in_b(b2),
    .add_a(aa2), .add_b(ab2), .add_o(o2), .out_valid(ov2), .out_ready(1'b1),
    .out_sum(sum2), .out_err(err2), .err_cnt(cnt2)
  );

  // ---------------- u3: no retries, 2-bit counter, always-on a<b fault
  logic       v3 = 0, rdy3, ov3, err3;
  logic [3:0] a3 = 0, b3 = 0, aa3, ab3;
  logic [4:0] o3, sum3;
  logic [1:0] cnt3;

  assign o3 = {1'b0, aa3} + {1'b0, ab3} + ((aa3 < ab3) ? 5'd1 : 5'd0);

  addr4u_rex_ctrl #(.SETTLE_CYC(1), .MAX_RETRY(0), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_a(a3), .in_b(b3),
    .add_a(aa3), .add_b(ab3), .add_o(o3), .out_valid(ov3), .out_ready(1'b1),
    .out_sum(sum3), .out_err(err3), .err_cnt(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a pair to u1; returns just after the accept edge
  task automatic accept1(input logic [3:0] a, input logic [3:0] b);
    a1 = a; b1 = b; v1 = 1'b1;
    tick();
    v1 = 1'b0;
  endtask

  // cycles until u1 out_valid, bounded
  task automatic wait_out1(output int lat);
    lat = 0;
    while (!ov1 && lat < 40) begin tick(); lat++; end
  endtask

  task automatic release1();
    ordy1 = 1'b1;
    tick();
    ordy1 = 1'b0;
    check("rel_out_valid", 32'(ov1), 32'd0);
    check("rel_in_ready", 32'(rdy1), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int bad;

    // reset state
    tick(); tick();
    check("rst_in_ready", 32'(rdy1), 32'd0);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_out_sum", 32'(sum1), 32'd0);
    check("rst_err_cnt", 32'(cnt1), 32'd0);
    check("rst_add_a", 32'(aa1), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(rdy1), 32'd1);

    // 1: 9+7, in_valid held with other operands while busy must be ignored
    accept1(4'd9, 4'd7);
    v1 = 1'b1; a1 = 4'd1; b1 = 4'd1;
    check("t1_busy_in_ready", 32'(rdy1), 32'd0);
    wait_out1(lat);
    v1 = 1'b0;
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_sum", 32'(sum1), 32'd16);
    check("t1_err", 32'(err1), 32'd0);
    check("t1_err_cnt", 32'(cnt1), 32'd0);
    check("t1_add_a_held", 32'(aa1), 32'd7);
    check("t1_add_b_held", 32'(ab1), 32'd9);
    release1();

    // 2: 15+15 with back-pressure
    accept1(4'd15, 4'd15);
    wait_out1(lat);
    check("t2_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("t2_sum_hold", 32'(sum1), 32'd30);
      check("t2_valid_hold", 32'(ov1), 32'd1);
      check("t2_in_ready_low", 32'(rdy1), 32'd0);
      tick();
    end
    release1();

    // 3: persistent a<b fault, retries exhausted
    lt_fault = 1'b1;
    accept1(4'd2, 4'd5);
    wait_out1(lat);
    check("t3_latency", 32'(lat), 32'd9);
    check("t3_sum", 32'(sum1), 32'd7);
    check("t3_err", 32'(err1), 32'd1);
    check("t3_err_cnt", 32'(cnt1), 32'd3);
    release1();
    lt_fault = 1'b0;

    // 4: fault during first EXEC1 only, recovered by one retry
    rst = 1'b1; tick(); rst = 1'b0; tick();
    flip_lsb = 1'b1;
    accept1(4'd3, 4'd4);
    tick();
    flip_lsb = 1'b0;
    wait_out1(lat);
    check("t4_latency", 32'(lat + 1), 32'd6);
    check("t4_sum", 32'(sum1), 32'd7);
    check("t4_err", 32'(err1), 32'd0);
    check("t4_err_cnt", 32'(cnt1), 32'd1);
    release1();

    // 5: reset while in EXEC2
    accept1(4'd6, 4'd1);
    tick();
    rst = 1'b1;
    #1;
    check("t5_out_valid", 32'(ov1), 32'd0);
    check("t5_out_sum", 32'(sum1), 32'd0);
    check("t5_add_a", 32'(aa1), 32'd0);
    check("t5_add_b", 32'(ab1), 32'd0);
    check("t5_err_cnt", 32'(cnt1), 32'd0);
    check("t5_in_ready_rst", 32'(rdy1), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_in_ready_after", 32'(rdy1), 32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (ov1) bad++;
      tick();
    end
    check("t5_no_out_valid", 32'(bad), 32'd0);

    // 6: slow netlist, exhaustive operands
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a2 = 4'(a); b2 = 4'(b); v2 = 1'b1;
        tick();
        v2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 40) begin tick(); lat++; end
        if (a == 0 && b == 0) check("t6_latency", 32'(lat), 32'd7);
        if ({err2, sum2} !== {1'b0, 5'(a + b)}) bad++;
        tick();
      end
    end
    check("t6_pairs_wrong", 32'(bad), 32'd0);
    check("t6_err_cnt", 32'(cnt2), 32'd0);

    // 7: no retry allowed, counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a3 = 4'd4; b3 = 4'd4; end
      else        begin a3 = 4'd2; b3 = 4'd5; end
      v3 = 1'b1;
      tick();
      v3 = 1'b0;
      lat = 0;
      while (!ov3 && lat < 40) begin tick(); lat++; end
      check("t7_latency", 32'(lat), 32'd3);
      check("t7_sum", 32'(sum3), (k == 4) ? 32'd8 : 32'd7);
      check("t7_err", 32'(err3), (k == 4) ? 32'd0 : 32'd1);
      check("t7_err_cnt", 32'(cnt3), (k >= 2) ? 32'd3 : 32'(k + 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
